// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile: parametrised AXI4-Lite CSR slave with RW, RO and W1C registers.
// AW and W are captured independently into one-entry holding registers and commit
// together; reads are registered and can issue back to back.
module axi4_lite_regfile #(
  parameter int                                ADDR_WIDTH = 32,
  parameter int                                DATA_WIDTH = 32,
  parameter int                                NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]               RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]               W1C_MASK   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]    RESET_VAL  = '0
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [ADDR_WIDTH-1:0]                awaddr,
  input  logic                                 awvalid,
  output logic                                 awready,
  input  logic [DATA_WIDTH-1:0]                wdata,
  input  logic [DATA_WIDTH/8-1:0]              wstrb,
  input  logic                                 wvalid,
  output logic                                 wready,
  output logic [1:0]                           bresp,
  output logic                                 bvalid,
  input  logic                                 bready,
  input  logic [ADDR_WIDTH-1:0]                araddr,
  input  logic                                 arvalid,
  output logic                                 arready,
  output logic [DATA_WIDTH-1:0]                rdata,
  output logic [1:0]                           rresp,
  output logic                                 rvalid,
  input  logic                                 rready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]       hw_ro_data,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]       hw_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0]       reg_q,
  output logic [NUM_REGS-1:0]                  wr_pulse,
  output logic                                 irq
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(NUM_REGS);
  localparam int DEC_W      = ADDR_LSB + IDX_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // irq must already reflect any W1C bit that comes out of reset set
  function automatic logic irq_reset_value();
    logic v;
    v = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (W1C_MASK[i]) v = v | (|RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH]);
    return v;
  endfunction
  localparam logic IRQ_RST = irq_reset_value();

  // write holding registers
  logic                    r_aw_full;
  logic [ADDR_WIDTH-1:0]   r_aw_addr;
  logic                    r_w_full;
  logic [DATA_WIDTH-1:0]   r_w_data;
  logic [STRB_WIDTH-1:0]   r_w_strb;
  // response / read state
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic                    r_rvalid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic [NUM_REGS-1:0]     r_wr_pulse;
  logic                    r_irq;

  logic                    w_commit;
  logic [IDX_W-1:0]        w_aw_idx;
  logic                    w_aw_legal;
  logic [IDX_W-1:0]        w_ar_idx;
  logic                    w_ar_legal;
  logic                    w_arready;
  logic                    w_ar_fire;
  logic [DATA_WIDTH-1:0]   w_wmask;
  logic [DATA_WIDTH-1:0]   w_rd_val [NUM_REGS];
  logic [NUM_REGS-1:0]     w_pulse_hit;
  logic [NUM_REGS-1:0]     w_irq_src;

  // Address decode: everything above the index field must be zero and the index in range
  assign w_aw_idx   = r_aw_addr[ADDR_LSB +: IDX_W];
  assign w_aw_legal = ((r_aw_addr >> DEC_W) == '0) && ({1'b0, w_aw_idx} < (IDX_W+1)'(NUM_REGS));
  assign w_ar_idx   = araddr[ADDR_LSB +: IDX_W];
  assign w_ar_legal = ((araddr >> DEC_W) == '0) && ({1'b0, w_ar_idx} < (IDX_W+1)'(NUM_REGS));

  // A held AW+W pair commits only when the B slot is free (or being drained this cycle)
  assign w_commit  = r_aw_full && r_w_full && (!r_bvalid || bready);
  assign w_arready = !r_rvalid || rready;
  assign w_ar_fire = arvalid && w_arready;

  genvar gi;
  for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_mask
    assign w_wmask[gi*8 +: 8] = {8{r_w_strb[gi]}};
  end

  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam bit IS_RO  = RO_MASK[gi];
    localparam bit IS_W1C = W1C_MASK[gi];
    logic [DATA_WIDTH-1:0] r_val;
    logic [DATA_WIDTH-1:0] w_next;
    logic                  w_hit;

    assign w_hit = w_commit && w_aw_legal && (int'(w_aw_idx) == gi);

    // Next value: software write first, then hardware set so a same-cycle set beats a clear
    always_comb begin
      w_next = r_val;
      if (w_hit && !IS_RO) begin
        if (IS_W1C) w_next = r_val & ~(r_w_data & w_wmask);
        else        w_next = (r_val & ~w_wmask) | (r_w_data & w_wmask);
      end
      if (IS_W1C) w_next = w_next | hw_set[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Register storage; RO slots hold zero and are never written
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_val <= IS_RO ? '0 : RESET_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
      else          r_val <= w_next;
    end

    assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = IS_RO ? '0 : r_val;
    assign w_rd_val[gi]    = IS_RO ? hw_ro_data[gi*DATA_WIDTH +: DATA_WIDTH] : r_val;
    assign w_pulse_hit[gi] = w_hit && !IS_RO;
    assign w_irq_src[gi]   = IS_W1C && (|r_val);
  end

  // AW/W holding registers: each fills on its own handshake and empties on commit
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (awvalid && !r_aw_full) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= awaddr;
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (wvalid && !r_w_full) begin
        r_w_full <= 1'b1;
        r_w_data <= wdata;
        r_w_strb <= wstrb;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
    end
  end

  // Write response: raised on commit, held until the master accepts it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_aw_legal ? RESP_OKAY : RESP_SLVERR;
    end else if (bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read data path: sampled at AR handshake, so a same-cycle commit is not yet visible
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_legal ? w_rd_val[w_ar_idx] : '0;
      r_rresp  <= w_ar_legal ? RESP_OKAY : RESP_SLVERR;
    end else if (rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // Sideband: write strobe one cycle after commit, interrupt one cycle after W1C change
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_pulse <= '0;
      r_irq      <= IRQ_RST;
    end else begin
      r_wr_pulse <= w_pulse_hit;
      r_irq      <= |w_irq_src;
    end
  end

  assign awready  = !r_aw_full;
  assign wready   = !r_w_full;
  assign bvalid   = r_bvalid;
  assign bresp    = r_bresp;
  assign arready  = w_arready;
  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign rresp    = r_rresp;
  assign wr_pulse = r_wr_pulse;
  assign irq      = r_irq;
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: 8 registers, reg1/reg3 RO, reg5 W1C.
// Expected read data and write responses are queued when a transaction is driven
// and checked by monitors when the beat completes.
module tb_axi4_lite_regfile;
  localparam int NR = 8;
  localparam logic [7:0] RO_M  = 8'h0A;
  localparam logic [7:0] W1C_M = 8'h20;
  localparam logic [255:0] RST_V = {32'h8000_0001, 32'h0000_00FF, 32'h0000_0000, 32'hDEAD_BEEF,
                                    32'h3333_3333, 32'h0000_0000, 32'h5555_5555, 32'h1111_0000};

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [31:0]  awaddr;
  logic         awvalid, awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic [31:0]  araddr;
  logic         arvalid, arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid, rready;
  logic [255:0] hw_ro_data, hw_set, reg_q;
  logic [7:0]   wr_pulse;
  logic         irq;

  int           n_err = 0;
  int           n_checks = 0;
  int           cyc = 0;
  logic [33:0]  exp_r[$];
  logic [1:0]   exp_b[$];
  int           r_beats[$];
  logic [31:0]  m_reg[NR];
  logic [33:0]  r_exp_cur;
  logic [1:0]   b_exp_cur;
  logic [31:0]  old_val;

  axi4_lite_regfile #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR),
    .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RESET_VAL(RST_V)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .hw_ro_data(hw_ro_data), .hw_set(hw_set), .reg_q(reg_q),
    .wr_pulse(wr_pulse), .irq(irq)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_err++;
    $error("FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = RO_M[i] ? 32'h0 : RST_V[i*32 +: 32];
  endfunction

  function automatic logic [255:0] model_q();
    logic [255:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = m_reg[i];
    return v;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    int idx;
    if ((a >> 5) != 0) return 2'b10;
    idx = int'(a[4:2]);
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    if (RO_M[idx]) return 2'b00;
    if (W1C_M[idx]) m_reg[idx] = m_reg[idx] & ~(d & m);
    else            m_reg[idx] = (m_reg[idx] & ~m) | (d & m);
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] a);
    int idx;
    if ((a >> 5) != 0) return {2'b10, 32'h0};
    idx = int'(a[4:2]);
    return {2'b00, RO_M[idx] ? hw_ro_data[idx*32 +: 32] : m_reg[idx]};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge aclk) begin
    if (aresetn && rvalid && rready) begin
      r_beats.push_back(cyc);
      if (exp_r.size() == 0) begin
        timeout_fail("r_unexpected");
      end else begin
        r_exp_cur = exp_r.pop_front();
        $display("R beat: rdata=%08h rresp=%0d", rdata, rresp);
        check("rbeat", 256'({rresp, rdata}), 256'(r_exp_cur));
      end
    end
    if (aresetn && bvalid && bready) begin
      if (exp_b.size() == 0) begin
        timeout_fail("b_unexpected");
      end else begin
        b_exp_cur = exp_b.pop_front();
        $display("B beat: bresp=%0d", bresp);
        check("bresp", 256'(bresp), 256'(b_exp_cur));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // lead > 0: W one cycle before AW; lead < 0: AW first; 0: together
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    bit aw_done;
    bit w_done;
    int t;
    aw_done = 0; w_done = 0; t = 0;
    exp_b.push_back(model_write(a, d, s));
    awaddr = a; wdata = d; wstrb = s;
    awvalid = (lead <= 0);
    wvalid  = (lead >= 0);
    while (!(aw_done && w_done) && t < 50) begin
      @(negedge aclk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge aclk);
      #1;
      awvalid = !aw_done;
      wvalid  = !w_done;
      t++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) timeout_fail("write_handshake");
  endtask

  task automatic do_read(input logic [31:0] a, input logic [33:0] e);
    bit done;
    int t;
    done = 0; t = 0;
    exp_r.push_back(e);
    araddr = a;
    arvalid = 1'b1;
    while (!done && t < 50) begin
      @(negedge aclk);
      if (arready) done = 1;
      @(posedge aclk);
      #1;
      t++;
    end
    arvalid = 1'b0;
    if (!done) timeout_fail("read_handshake");
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && t < 100) begin
      step();
      t++;
    end
    if (exp_r.size() != 0 || exp_b.size() != 0) begin
      timeout_fail("idle_wait");
      exp_r.delete();
      exp_b.delete();
    end
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_awready"}, 256'(awready), 256'(1'b1));
    check({tag, "_wready"},  256'(wready),  256'(1'b1));
    check({tag, "_arready"}, 256'(arready), 256'(1'b1));
    check({tag, "_bvalid"},  256'(bvalid),  256'(1'b0));
    check({tag, "_bresp"},   256'(bresp),   256'(2'b00));
    check({tag, "_rvalid"},  256'(rvalid),  256'(1'b0));
    check({tag, "_rdata"},   256'(rdata),   256'(32'h0));
    check({tag, "_rresp"},   256'(rresp),   256'(2'b00));
    check({tag, "_wr_pulse"}, 256'(wr_pulse), 256'(8'h00));
    check({tag, "_irq"},     256'(irq),     256'(1'b0));
    check({tag, "_reg_q"},   reg_q,         model_q());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    aresetn = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    hw_set = '0;
    for (int i = 0; i < NR; i++) hw_ro_data[i*32 +: 32] = 32'hCAFE_0000 | 32'(i);
    model_reset();
    #2 aresetn = 1'b0;
    #1 check_reset_state("reset");
    step();
    step();
    aresetn = 1'b1;
    step();

    // reset values of every register, RO words read live hardware data
    for (int i = 0; i < NR; i++) do_read(32'(i * 4), model_read(32'(i * 4)));
    wait_idle();

    // W leads AW by one cycle, partial strobes, one-cycle wr_pulse
    do_write(32'h08, 32'hA5A5_1234, 4'b0101, 1);
    check("pulse_before_commit", 256'(wr_pulse), 256'(8'h00));
    step();
    check("pulse_reg2", 256'(wr_pulse), 256'(8'h04));
    check("reg2_value", 256'(reg_q[2*32 +: 32]), 256'(32'h00A5_0034));
    step();
    check("pulse_one_cycle", 256'(wr_pulse), 256'(8'h00));
    wait_idle();

    // W1C set by hardware; set ignored on a RW register
    hw_set[5*32 +: 32] = 32'h0000_0011;
    hw_set[2*32 +: 32] = 32'hFFFF_FFFF;
    step();
    hw_set = '0;
    m_reg[5] = m_reg[5] | 32'h11;
    check("w1c_set_regq", reg_q, model_q());
    check("irq_lag", 256'(irq), 256'(1'b0));
    step();
    check("irq_set", 256'(irq), 256'(1'b1));
    do_write(32'h14, 32'h0000_0001, 4'hF, 0);
    wait_idle();
    check("w1c_clear_bit0", 256'(reg_q[5*32 +: 32]), 256'(32'h10));
    check("irq_still_set", 256'(irq), 256'(1'b1));
    // clear and set of bit4 in the same commit cycle: set wins
    do_write(32'h14, 32'h0000_0010, 4'hF, 0);
    hw_set[5*32 +: 32] = 32'h0000_0010;
    step();
    hw_set = '0;
    m_reg[5] = m_reg[5] | 32'h10;
    wait_idle();
    check("w1c_set_wins", 256'(reg_q[5*32 +: 32]), 256'(32'h10));
    do_write(32'h14, 32'h0000_0010, 4'hF, -1);
    wait_idle();
    check("w1c_cleared", 256'(reg_q[5*32 +: 32]), 256'(32'h0));
    check("irq_cleared", 256'(irq), 256'(1'b0));

    // illegal addresses: SLVERR, no state change, no strobe
    do_write(32'h20, 32'h1234_5678, 4'hF, 0);
    check("illegal_idx_pulse", 256'(wr_pulse), 256'(8'h00));
    step();
    check("illegal_idx_pulse2", 256'(wr_pulse), 256'(8'h00));
    do_write(32'h1000_0000, 32'h8765_4321, 4'hF, 1);
    step();
    check("illegal_hi_pulse", 256'(wr_pulse), 256'(8'h00));
    wait_idle();
    check("illegal_regq", reg_q, model_q());
    do_read(32'h20, model_read(32'h20));
    do_read(32'h1000_0000, model_read(32'h1000_0000));
    wait_idle();

    // RO write accepted with OKAY but has no effect
    do_write(32'h04, 32'hFFFF_FFFF, 4'hF, -1);
    step();
    check("ro_no_pulse", 256'(wr_pulse), 256'(8'h00));
    wait_idle();
    check("ro_regq", reg_q, model_q());
    do_read(32'h04, model_read(32'h04));
    wait_idle();

    // read in the commit cycle of a write to the same register returns the old value
    old_val = m_reg[0];
    do_write(32'h00, 32'h7777_7777, 4'hF, 0);
    do_read(32'h00, {2'b00, old_val});
    wait_idle();
    check("prewrite_regq", 256'(reg_q[31:0]), 256'(32'h7777_7777));

    // 8 back-to-back reads with rready held high
    r_beats.delete();
    for (int i = 0; i < NR; i++) do_read(32'(i * 4), model_read(32'(i * 4)));
    wait_idle();
    check("burst_beats", 256'(r_beats.size()), 256'(NR));
    if (r_beats.size() == NR) check("burst_consecutive", 256'(r_beats[NR-1] - r_beats[0]), 256'(NR - 1));

    // R backpressure: arready low, rdata held
    rready = 1'b0;
    do_read(32'h10, model_read(32'h10));
    step();
    check("rbp_arready", 256'(arready), 256'(1'b0));
    check("rbp_rdata", 256'(rdata), 256'(m_reg[4]));
    step();
    check("rbp_rdata_held", 256'(rdata), 256'(m_reg[4]));
    rready = 1'b1;
    wait_idle();

    // B backpressure: second write stalls in the holding registers, responses in order
    bready = 1'b0;
    do_write(32'h18, 32'h1234_5678, 4'hF, 0);
    do_write(32'h40, 32'h0BAD_0BAD, 4'hF, 0);
    step();
    check("bbp_awready", 256'(awready), 256'(1'b0));
    check("bbp_wready", 256'(wready), 256'(1'b0));
    check("bbp_bvalid", 256'(bvalid), 256'(1'b1));
    check("bbp_regq", reg_q, model_q());
    bready = 1'b1;
    wait_idle();

    // asynchronous reset in the middle of a stall
    bready = 1'b0;
    do_write(32'h18, 32'hFFFF_0000, 4'hF, 0);
    do_write(32'h1C, 32'h0BAD_0000, 4'hF, 0);
    step();
    #2 aresetn = 1'b0;
    exp_b.delete();
    model_reset();
    #1 check_reset_state("midreset");
    step();
    aresetn = 1'b1;
    bready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("post_reset_bvalid", 256'(bvalid), 256'(1'b0));
    check("post_reset_regq", reg_q, model_q());
    do_read(32'h1C, model_read(32'h1C));
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
